// File: rtl/i2s_tx_if.sv
// ---------------------------------------------------------------------------
// i2s_tx_if
// Sample-side bus between the effects chain and the I2S transmitter.
//
// Signals:
//   ready_in    upstream -> tx  one-cycle strobe, signal_in valid
//   signal_in   upstream -> tx  16-bit signed sample
//   sample_req  tx -> upstream  one-cycle pulse at each frame start
//   fifo_level  tx -> upstream  FIFO occupancy, 0..2
//   underrun    tx -> upstream  pulse when a frame starts with the FIFO empty
//   overflow    tx -> upstream  pulse when a pushed sample is dropped
//
// Modports: master = upstream producer, slave = i2s_tx.
// ---------------------------------------------------------------------------
interface i2s_tx_if;
    logic               ready_in;
    logic signed [15:0] signal_in;
    logic               sample_req;
    logic [1:0]         fifo_level;
    logic               underrun;
    logic               overflow;

    modport master (
        output ready_in,
        output signal_in,
        input  sample_req,
        input  fifo_level,
        input  underrun,
        input  overflow
    );

    modport slave (
        input  ready_in,
        input  signal_in,
        output sample_req,
        output fifo_level,
        output underrun,
        output overflow
    );
endinterface

// File: rtl/i2s_tx.sv
// ---------------------------------------------------------------------------
// i2s_tx
// Mono-to-stereo Philips I2S transmitter. Samples from the effects chain are
// buffered in a 2-entry FIFO; one sample is popped per 64-BCLK frame and sent
// MSB first on both the left and right 32-bit slots (16 data bits, 16 zeros).
//
// Parameters:
//   CLK_DIV   BCLK half-period in clk_50m cycles (>= 2)
//
// Ports:
//   clk_50m    system clock
//   rst        asynchronous active-high reset (flushes the FIFO)
//   bus        i2s_tx_if.slave sample bus (ready_in/signal_in in,
//              sample_req/fifo_level/underrun/overflow out)
//   i2s_bclk   bit clock
//   i2s_lrck   word select, 0 = left
//   i2s_sdata  serial data, changes on BCLK falling edges only
//
// Build option:
//   I2S_TX_ZERO_ON_UNDERRUN_EN  defined: an underrun frame sends silence
//                               undefined: an underrun frame repeats the
//                               previous sample
// ---------------------------------------------------------------------------
module i2s_tx #(
    parameter int CLK_DIV = 8
) (
    input  logic     clk_50m,
    input  logic     rst,
    i2s_tx_if.slave  bus,
    output logic     i2s_bclk,
    output logic     i2s_lrck,
    output logic     i2s_sdata
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] divcnt, divcnt_nxt;
    logic [5:0]    bitcnt, bitcnt_nxt;
    logic          bclk_nxt;
    logic          lrck_nxt;
    logic          sdata_nxt;
    logic [15:0]   hold, hold_nxt;
    logic [15:0]   mem0, mem0_nxt;
    logic [15:0]   mem1, mem1_nxt;
    logic [1:0]    level, level_nxt;
    logic          req_nxt;
    logic          underrun_nxt;
    logic          overflow_nxt;

    logic          fall;
    logic          frame_start;
    logic          push;
    logic          pop;
    logic [3:0]    bit_sel;

    // Next-state logic for divider, bit counter, FIFO, holding register and
    // the serial outputs. Everything the DAC sees is decided here and then
    // registered, so no input reaches an output combinationally.
    always_comb begin
        divcnt_nxt   = divcnt + DW'(1);
        bclk_nxt     = i2s_bclk;
        bitcnt_nxt   = bitcnt;
        mem0_nxt     = mem0;
        mem1_nxt     = mem1;
        level_nxt    = level;
        hold_nxt     = hold;
        overflow_nxt = 1'b0;
        lrck_nxt     = i2s_lrck;
        sdata_nxt    = i2s_sdata;
        bit_sel      = 4'd0;

        if (divcnt == DIV_LAST) begin
            divcnt_nxt = '0;
            bclk_nxt   = ~i2s_bclk;
        end

        // A fall event is the cycle whose edge takes BCLK from 1 to 0.
        fall = (divcnt == DIV_LAST) && i2s_bclk;
        if (fall) begin
            bitcnt_nxt = bitcnt + 6'd1;
        end
        frame_start = fall && (bitcnt_nxt == 6'd0);

        push = bus.ready_in;
        pop  = frame_start && (level != 2'd0);

        // FIFO: mem0 is always the head. A push that coincides with a pop of
        // a full FIFO slides mem1 forward and takes its place, so nothing is
        // lost; a push into an empty FIFO never bypasses into hold.
        if (pop && push) begin
            if (level == 2'd2) begin
                mem0_nxt = mem1;
                mem1_nxt = bus.signal_in;
            end else begin
                mem0_nxt = bus.signal_in;
            end
        end else if (pop) begin
            mem0_nxt  = mem1;
            level_nxt = level - 2'd1;
        end else if (push) begin
            if (level == 2'd2) begin
                overflow_nxt = 1'b1;
            end else begin
                if (level == 2'd0) begin
                    mem0_nxt = bus.signal_in;
                end else begin
                    mem1_nxt = bus.signal_in;
                end
                level_nxt = level + 2'd1;
            end
        end

        if (frame_start) begin
            if (level != 2'd0) begin
                hold_nxt = mem0;
            end else begin
`ifdef I2S_TX_ZERO_ON_UNDERRUN_EN
                hold_nxt = 16'h0000;
`else
                hold_nxt = hold;
`endif
            end
        end

        req_nxt      = frame_start;
        underrun_nxt = frame_start && (level == 2'd0);

        // Data bits occupy b = 0..15 and 32..47, i.e. bit 4 of b clear; the
        // bit index 15-(b mod 16) is just the inverted low nibble. The
        // freshly loaded hold is used so the MSB leaves on the frame start.
        if (fall) begin
            bit_sel   = ~bitcnt_nxt[3:0];
            sdata_nxt = bitcnt_nxt[4] ? 1'b0 : hold_nxt[bit_sel];
            lrck_nxt  = (bitcnt_nxt >= 6'd31) && (bitcnt_nxt <= 6'd62);
        end
    end

    // State register. bitcnt resets to 63 so the first fall event lands on
    // b = 0 and starts a frame.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            divcnt         <= '0;
            bitcnt         <= 6'd63;
            i2s_bclk       <= 1'b0;
            i2s_lrck       <= 1'b0;
            i2s_sdata      <= 1'b0;
            hold           <= 16'h0000;
            mem0           <= 16'h0000;
            mem1           <= 16'h0000;
            level          <= 2'd0;
            bus.sample_req <= 1'b0;
            bus.underrun   <= 1'b0;
            bus.overflow   <= 1'b0;
        end else begin
            divcnt         <= divcnt_nxt;
            bitcnt         <= bitcnt_nxt;
            i2s_bclk       <= bclk_nxt;
            i2s_lrck       <= lrck_nxt;
            i2s_sdata      <= sdata_nxt;
            hold           <= hold_nxt;
            mem0           <= mem0_nxt;
            mem1           <= mem1_nxt;
            level          <= level_nxt;
            bus.sample_req <= req_nxt;
            bus.underrun   <= underrun_nxt;
            bus.overflow   <= overflow_nxt;
        end
    end

    assign bus.fifo_level = level;

endmodule

// File: tb/tb_i2s_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx
// Self-checking bench for i2s_tx at CLK_DIV = 8. Frames are captured one bit
// per BCLK period in the cycle right after each falling edge and compared
// with hand-computed sample words. Honours I2S_TX_ZERO_ON_UNDERRUN_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2s_tx;

    localparam int CLK_DIV = 8;
    localparam int BITP    = 2 * CLK_DIV;
    localparam int FRAME   = 64 * BITP;

`ifdef I2S_TX_ZERO_ON_UNDERRUN_EN
    localparam logic [15:0] REP_7FFF = 16'h0000;
    localparam logic [15:0] REP_3333 = 16'h0000;
`else
    localparam logic [15:0] REP_7FFF = 16'h7FFF;
    localparam logic [15:0] REP_3333 = 16'h3333;
`endif

    typedef struct {
        logic        push;
        logic [15:0] push_val;
        logic [15:0] exp_word;
        logic        exp_underrun;
        logic [1:0]  exp_max_level;
    } frame_vec_t;

    logic clk_50m = 1'b0;
    logic rst;
    logic i2s_bclk;
    logic i2s_lrck;
    logic i2s_sdata;

    int n_checks = 0;
    int n_fail   = 0;

    i2s_tx_if bus ();

    i2s_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk_50m   (clk_50m),
        .rst       (rst),
        .bus       (bus),
        .i2s_bclk  (i2s_bclk),
        .i2s_lrck  (i2s_lrck),
        .i2s_sdata (i2s_sdata)
    );

    always #10 clk_50m = ~clk_50m;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [15:0] data);
        bus.ready_in  = valid;
        bus.signal_in = data;
    endtask

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic waitFrameStart();
        int n;
        n = 0;
        while (bus.sample_req !== 1'b1 && n < 2 * FRAME) begin
            tick();
            n++;
        end
        checkOutput("frame_start_seen", {31'd0, bus.sample_req}, 32'd1);
    endtask

    // Called in a frame-start cycle; leaves the bench in the next one.
    task automatic captureFrame(input logic push_en, input logic [15:0] push_val,
                                output logic [15:0] left_w, output logic [15:0] right_w,
                                output logic pad_ok, output logic wave_ok,
                                output logic req_ok, output logic und,
                                output logic ovf, output logic [1:0] max_lvl);
        logic [63:0] bits;
        int b;
        bits    = '0;
        wave_ok = 1'b1;
        ovf     = 1'b0;
        max_lvl = 2'd0;
        und     = bus.underrun;
        req_ok  = (bus.sample_req === 1'b1);
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0 && bus.sample_req !== 1'b0) req_ok = 1'b0;
            if (bus.overflow === 1'b1) ovf = 1'b1;
            if (bus.fifo_level > max_lvl) max_lvl = bus.fifo_level;
            if (k % BITP == 0) begin
                b = k / BITP;
                bits[b] = i2s_sdata;
                if (i2s_bclk !== 1'b0) wave_ok = 1'b0;
                if (i2s_lrck !== ((b >= 31 && b <= 62) ? 1'b1 : 1'b0)) wave_ok = 1'b0;
            end
            if (k % BITP == CLK_DIV && i2s_bclk !== 1'b1) wave_ok = 1'b0;
            if (push_en && k == 2) applyStimulus(1'b1, push_val);
            else applyStimulus(1'b0, 16'h0000);
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            left_w[15-i]  = bits[i];
            right_w[15-i] = bits[32+i];
        end
        pad_ok = (bits[31:16] === 16'h0000) && (bits[63:48] === 16'h0000);
    endtask

    task automatic checkFrame(input string tag, input logic push_en,
                              input logic [15:0] push_val, input logic [15:0] exp_word,
                              input logic exp_und, input logic [1:0] exp_max);
        logic [15:0] lw, rw;
        logic pad_ok, wave_ok, req_ok, und, ovf;
        logic [1:0] max_lvl;
        captureFrame(push_en, push_val, lw, rw, pad_ok, wave_ok, req_ok, und, ovf, max_lvl);
        checkOutput({tag, "_left"},     {16'd0, lw}, {16'd0, exp_word});
        checkOutput({tag, "_right"},    {16'd0, rw}, {16'd0, exp_word});
        checkOutput({tag, "_pad"},      {31'd0, pad_ok}, 32'd1);
        checkOutput({tag, "_wave"},     {31'd0, wave_ok}, 32'd1);
        checkOutput({tag, "_req"},      {31'd0, req_ok}, 32'd1);
        checkOutput({tag, "_underrun"}, {31'd0, und}, {31'd0, exp_und});
        checkOutput({tag, "_overflow"}, {31'd0, ovf}, 32'd0);
        checkOutput({tag, "_maxlevel"}, {30'd0, max_lvl}, {30'd0, exp_max});
    endtask

    // Entered right after a clock edge with rst high; releases reset so the
    // current cycle is cycle 0 and checks the restart timing up to cycle 16.
    task automatic releaseAndCheck(input string tag, input logic push_en);
        rst = 1'b0;
        ticks(2);
        if (push_en) applyStimulus(1'b1, 16'h8001);
        tick();
        applyStimulus(1'b0, 16'h0000);
        checkOutput({tag, "_level_c3"}, {30'd0, bus.fifo_level}, {31'd0, push_en});
        ticks(4);
        checkOutput({tag, "_bclk_c7"}, {31'd0, i2s_bclk}, 32'd0);
        tick();
        checkOutput({tag, "_bclk_c8"}, {31'd0, i2s_bclk}, 32'd1);
        ticks(7);
        checkOutput({tag, "_bclk_c15"}, {31'd0, i2s_bclk}, 32'd1);
        checkOutput({tag, "_req_c15"}, {31'd0, bus.sample_req}, 32'd0);
        tick();
        checkOutput({tag, "_bclk_c16"}, {31'd0, i2s_bclk}, 32'd0);
        checkOutput({tag, "_req_c16"}, {31'd0, bus.sample_req}, 32'd1);
        checkOutput({tag, "_und_c16"}, {31'd0, bus.underrun}, {31'd0, ~push_en});
        checkOutput({tag, "_level_c16"}, {30'd0, bus.fifo_level}, 32'd0);
        checkOutput({tag, "_sdata_c16"}, {31'd0, i2s_sdata}, {31'd0, push_en});
        checkOutput({tag, "_lrck_c16"}, {31'd0, i2s_lrck}, 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_bclk"},  {31'd0, i2s_bclk}, 32'd0);
        checkOutput({tag, "_lrck"},  {31'd0, i2s_lrck}, 32'd0);
        checkOutput({tag, "_sdata"}, {31'd0, i2s_sdata}, 32'd0);
        checkOutput({tag, "_req"},   {31'd0, bus.sample_req}, 32'd0);
        checkOutput({tag, "_und"},   {31'd0, bus.underrun}, 32'd0);
        checkOutput({tag, "_ovf"},   {31'd0, bus.overflow}, 32'd0);
        checkOutput({tag, "_level"}, {30'd0, bus.fifo_level}, 32'd0);
    endtask

    // Hard stop in case the design never produces frame timing.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no end of test, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        frame_vec_t vecs [7];
        vecs[0] = '{1'b1, 16'hABCD, 16'h1234, 1'b0, 2'd1};
        vecs[1] = '{1'b1, 16'h5A5A, 16'hABCD, 1'b0, 2'd1};
        vecs[2] = '{1'b1, 16'h7FFF, 16'h5A5A, 1'b0, 2'd1};
        vecs[3] = '{1'b0, 16'h0000, 16'h7FFF, 1'b0, 2'd0};
        vecs[4] = '{1'b0, 16'h0000, REP_7FFF, 1'b1, 2'd0};
        vecs[5] = '{1'b1, 16'h8000, REP_7FFF, 1'b1, 2'd1};
        vecs[6] = '{1'b0, 16'h0000, 16'h8000, 1'b0, 2'd0};

        applyStimulus(1'b0, 16'h0000);
        rst = 1'b1;
        ticks(3);
        checkAllZero("reset");

        // Reset release and the first frame carrying 0x8001.
        releaseAndCheck("first", 1'b1);
        checkFrame("first_frame", 1'b1, 16'h1234, 16'h8001, 1'b0, 2'd1);

        // Steady pacing followed by an underrun run.
        for (int i = 0; i < 7; i++) begin
            checkFrame($sformatf("vec%0d", i), vecs[i].push, vecs[i].push_val,
                       vecs[i].exp_word, vecs[i].exp_underrun, vecs[i].exp_max_level);
        end

        // Overflow: three back-to-back pushes mid-frame.
        ticks(100);
        applyStimulus(1'b1, 16'h0001);
        tick();
        checkOutput("ovf_push1_flag", {31'd0, bus.overflow}, 32'd0);
        checkOutput("ovf_push1_level", {30'd0, bus.fifo_level}, 32'd1);
        applyStimulus(1'b1, 16'h0002);
        tick();
        checkOutput("ovf_push2_flag", {31'd0, bus.overflow}, 32'd0);
        checkOutput("ovf_push2_level", {30'd0, bus.fifo_level}, 32'd2);
        applyStimulus(1'b1, 16'h0003);
        tick();
        checkOutput("ovf_push3_flag", {31'd0, bus.overflow}, 32'd1);
        checkOutput("ovf_push3_level", {30'd0, bus.fifo_level}, 32'd2);
        applyStimulus(1'b0, 16'h0000);
        tick();
        checkOutput("ovf_pulse_end", {31'd0, bus.overflow}, 32'd0);
        waitFrameStart();
        checkFrame("ovf_frame1", 1'b0, 16'h0000, 16'h0001, 1'b0, 2'd1);
        checkFrame("ovf_frame2", 1'b0, 16'h0000, 16'h0002, 1'b0, 2'd0);

        // Push in the frame-start edge with the FIFO full.
        ticks(50);
        applyStimulus(1'b1, 16'h1111);
        tick();
        applyStimulus(1'b1, 16'h2222);
        tick();
        applyStimulus(1'b0, 16'h0000);
        ticks(FRAME - 1 - 52);
        checkOutput("full_pre_level", {30'd0, bus.fifo_level}, 32'd2);
        applyStimulus(1'b1, 16'h3333);
        tick();
        applyStimulus(1'b0, 16'h0000);
        checkOutput("full_sim_req", {31'd0, bus.sample_req}, 32'd1);
        checkOutput("full_sim_level", {30'd0, bus.fifo_level}, 32'd2);
        checkOutput("full_sim_ovf", {31'd0, bus.overflow}, 32'd0);
        checkOutput("full_sim_und", {31'd0, bus.underrun}, 32'd0);
        checkFrame("full_a", 1'b0, 16'h0000, 16'h1111, 1'b0, 2'd2);
        checkFrame("full_b", 1'b0, 16'h0000, 16'h2222, 1'b0, 2'd1);
        checkFrame("full_c", 1'b0, 16'h0000, 16'h3333, 1'b0, 2'd0);

        // Push in the frame-start edge with the FIFO empty.
        ticks(FRAME - 1);
        applyStimulus(1'b1, 16'h4444);
        tick();
        applyStimulus(1'b0, 16'h0000);
        checkOutput("empty_sim_req", {31'd0, bus.sample_req}, 32'd1);
        checkOutput("empty_sim_und", {31'd0, bus.underrun}, 32'd1);
        checkOutput("empty_sim_level", {30'd0, bus.fifo_level}, 32'd1);
        checkOutput("empty_sim_ovf", {31'd0, bus.overflow}, 32'd0);
        checkFrame("empty_a", 1'b0, 16'h0000, REP_3333, 1'b1, 2'd1);
        checkFrame("empty_b", 1'b0, 16'h0000, 16'h4444, 1'b0, 2'd0);

        // Mid-frame reset at b = 20 with one sample queued and BCLK high.
        ticks(2);
        applyStimulus(1'b1, 16'h6666);
        tick();
        applyStimulus(1'b0, 16'h0000);
        ticks(20 * BITP + CLK_DIV + 2 - 3);
        checkOutput("prerst_bclk", {31'd0, i2s_bclk}, 32'd1);
        checkOutput("prerst_level", {30'd0, bus.fifo_level}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        checkAllZero("midrst");
        ticks(3);
        releaseAndCheck("rst2", 1'b0);
        checkFrame("rst2_frame", 1'b0, 16'h0000, 16'h0000, 1'b1, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
